// File: rtl/modq_tw_reducer_if.sv
// ----------------------------------------------------------------------------
// modq_tw_reducer_if
//   Bundles the operand and result signals of the twiddle reducer.
//
//   Signals
//     expand  IN_W   unreduced operand, driven by the source (master)
//     tw_ack  1      result-valid strobe, driven by the reducer (slave)
//     TW_out  OUT_W  reduced twiddle, driven by the reducer (slave)
//
//   Modports
//     master  operand source: drives expand, observes tw_ack/TW_out
//     slave   reducer: observes expand, drives tw_ack/TW_out
// ----------------------------------------------------------------------------
interface modq_tw_reducer_if #(
    parameter int IN_W  = 26,
    parameter int OUT_W = 25
);
    logic [IN_W-1:0]  expand;
    logic             tw_ack;
    logic [OUT_W-1:0] TW_out;

    modport master (
        output expand,
        input  tw_ack,
        input  TW_out
    );

    modport slave (
        input  expand,
        output tw_ack,
        output TW_out
    );
endinterface

// File: rtl/modq_tw_reducer.sv
// ----------------------------------------------------------------------------
// modq_tw_reducer
//   Sequential modular reducer for the twiddle path: TW_out = expand mod Q.
//   Restoring shift-subtract, one operand bit per cycle (no divider or
//   multiplier). A conversion starts whenever the operand differs from the
//   last captured operand; a result is published with a tw_ack strobe
//   27 cycles after capture.
//
//   Ports
//     clock   in   1       single clock, rising edge
//     reset   in   1       asynchronous, active-high reset
//     tw_bus  slave        expand (in), tw_ack (out), TW_out (out)
//
//   Parameters
//     Q      modulus, 2 <= Q < 2**OUT_W
//     IN_W   width of expand
//     OUT_W  width of TW_out and of the internal remainder
//
//   Configuration
//     MODQ_TW_STICKY_ACK_EN  when defined, tw_ack is set when a result is
//                            published and held until the next conversion
//                            starts (or reset). Undefined: one-cycle pulse.
// ----------------------------------------------------------------------------
module modq_tw_reducer #(
    parameter int Q     = 641,
    parameter int IN_W  = 26,
    parameter int OUT_W = 25
) (
    input  logic           clock,
    input  logic           reset,
    modq_tw_reducer_if.slave tw_bus
);
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

    // Modulus widened to the trial-remainder width so the compare and
    // subtract happen at OUT_W+1 bits without truncation.
    localparam logic [OUT_W:0] Q_EXT = (OUT_W + 1)'(Q);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RED  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state,    state_d;
    logic [IN_W-1:0]  dividend, dividend_d;
    logic [IN_W-1:0]  last_in,  last_in_d;
    logic [OUT_W-1:0] rem,      rem_d;
    logic [CNT_W-1:0] cnt,      cnt_d;
    logic [OUT_W-1:0] tw_out_q, tw_out_d;
    logic             tw_ack_q, tw_ack_d;

    // Trial remainder: previous remainder with the next dividend bit shifted in.
    logic [OUT_W:0]   trial;

    assign trial = {rem, dividend[IN_W-1]};

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a hold/default value before the case so no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d    = state;
        dividend_d = dividend;
        last_in_d  = last_in;
        rem_d      = rem;
        cnt_d      = cnt;
        tw_out_d   = tw_out_q;
`ifdef MODQ_TW_STICKY_ACK_EN
        tw_ack_d   = tw_ack_q;
`else
        tw_ack_d   = 1'b0;
`endif

        unique case (state)
            IDLE: begin
                // No start port: any operand change (including the very first
                // operand after reset, compared against all-ones) starts work.
                if (tw_bus.expand != last_in) begin
                    dividend_d = tw_bus.expand;
                    last_in_d  = tw_bus.expand;
                    rem_d      = '0;
                    cnt_d      = CNT_W'(IN_W - 1);
                    tw_ack_d   = 1'b0;
                    state_d    = RED;
                end
            end

            RED: begin
                // rem < Q holds on entry, so trial < 2Q and one conditional
                // subtraction restores rem < Q.
                if (trial >= Q_EXT) begin
                    rem_d = OUT_W'(trial - Q_EXT);
                end else begin
                    rem_d = trial[OUT_W-1:0];
                end
                dividend_d = dividend << 1;
                if (cnt == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end

            DONE: begin
                tw_out_d = rem;
                tw_ack_d = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments so every register samples the values
    // computed before this edge, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            dividend <= '0;
            last_in  <= '1;
            rem      <= '0;
            cnt      <= '0;
            tw_out_q <= '0;
            tw_ack_q <= 1'b0;
        end else begin
            state    <= state_d;
            dividend <= dividend_d;
            last_in  <= last_in_d;
            rem      <= rem_d;
            cnt      <= cnt_d;
            tw_out_q <= tw_out_d;
            tw_ack_q <= tw_ack_d;
        end
    end

    assign tw_bus.TW_out = tw_out_q;
    assign tw_bus.tw_ack = tw_ack_q;

endmodule

// File: tb/tb_modq_tw_reducer.sv
// ----------------------------------------------------------------------------
// tb_modq_tw_reducer
//   Directed, self-checking bench for modq_tw_reducer (Q=641, IN_W=26,
//   OUT_W=25). Expected remainders are queued when an operand is driven and
//   compared when the reducer raises tw_ack. Outputs are sampled on the
//   falling clock edge. Works in both the pulse and sticky-ack builds.
// ----------------------------------------------------------------------------
module tb_modq_tw_reducer;
    localparam int Q     = 641;
    localparam int IN_W  = 26;
    localparam int OUT_W = 25;
    localparam int LAT   = 28;   // falling edges from a drive to the visible result
    localparam int WAIT_BUDGET = 200;

`ifdef MODQ_TW_STICKY_ACK_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;

    int tests_run    = 0;
    int tests_failed = 0;

    int unsigned exp_q[$];

    modq_tw_reducer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) tw_bus ();

    modq_tw_reducer #(
        .Q     (Q),
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .tw_bus (tw_bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for a rising tw_ack, then checks the result against the
    // scoreboard head and, when exp_lat > 0, the number of falling edges taken.
    task automatic wait_result(input string tag, input int exp_lat);
        int   n    = 0;
        bit   seen = 1'b0;
        logic prev;
        prev = tw_bus.tw_ack;
        while (!seen && n < WAIT_BUDGET) begin
            @(negedge clock);
            n++;
            if (tw_bus.tw_ack === 1'b1 && prev !== 1'b1) seen = 1'b1;
            prev = tw_bus.tw_ack;
        end
        if (!seen) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else if (exp_q.size() == 0) begin
            check({tag, "_unexpected_ack"}, 32'd1, 32'd0);
        end else begin
            check(tag, 32'(tw_bus.TW_out), exp_q.pop_front());
            if (exp_lat > 0) check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        end
    endtask

    // Drive an operand, expect its remainder with full latency, then check the
    // ack shape one cycle later (pulse: low again; sticky: still high).
    task automatic run_conv(input string tag, input logic [IN_W-1:0] value,
                            input int unsigned expected);
        tw_bus.expand = value;
        exp_q.push_back(expected);
        wait_result(tag, LAT);
        @(negedge clock);
        check({tag, "_ack_after"}, 32'(tw_bus.tw_ack), 32'(STICKY));
    endtask

    initial begin
        int rises;
        int high_cycles;
        logic prev_ack;

        // ---- 1: reset with expand=40, then release ----
        reset         = 1'b1;
        tw_bus.expand = 26'd40;
        repeat (3) @(negedge clock);
        check("t1_reset_tw_out", 32'(tw_bus.TW_out), 32'd0);
        check("t1_reset_ack",    32'(tw_bus.tw_ack), 32'd0);
        reset = 1'b0;
        exp_q.push_back(32'd40);
        wait_result("t1_40", LAT);
        @(negedge clock);
        check("t1_ack_after", 32'(tw_bus.tw_ack), 32'(STICKY));

        // ---- 2: ordinary operands ----
        run_conv("t2_1600", 26'd1600, 318);
        run_conv("t2_641",  26'd641,  0);
        run_conv("t2_1287", 26'd1287, 5);

        // ---- 3: full-width operands, including last_in's reset value ----
        run_conv("t3_3fffffe", 26'h3FFFFFE, 8);
        run_conv("t3_3ffffff", 26'h3FFFFFF, 9);

        // ---- 4: hold 1600 for 100 cycles -> exactly one result ----
        tw_bus.expand = 26'd1600;
        exp_q.push_back(32'd318);
        rises       = 0;
        high_cycles = 0;
        prev_ack    = tw_bus.tw_ack;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (tw_bus.tw_ack === 1'b1) high_cycles++;
            if (tw_bus.tw_ack === 1'b1 && prev_ack !== 1'b1) begin
                rises++;
                if (exp_q.size() != 0)
                    check("t4_1600", 32'(tw_bus.TW_out), exp_q.pop_front());
            end
            prev_ack = tw_bus.tw_ack;
        end
        check("t4_ack_rises", 32'(rises), 32'd1);
        check("t4_ack_high_cycles", 32'(high_cycles), STICKY ? 32'd73 : 32'd1);

        // ---- 5: operand change mid-conversion; latest value wins ----
        run_conv("t5_zero", 26'd0, 0);
        tw_bus.expand = 26'd1600;
        exp_q.push_back(32'd318);
        repeat (11) @(negedge clock);
        tw_bus.expand = 26'd2560000;
        exp_q.push_back(32'd487);
        wait_result("t5_inflight_1600", LAT - 11);
        wait_result("t5_next_2560000", LAT);
        @(negedge clock);
        check("t5_ack_after", 32'(tw_bus.tw_ack), 32'(STICKY));

        // ---- 6: reset mid-conversion aborts, then restart on 100 ----
        tw_bus.expand = 26'd5000;
        exp_q.push_back(32'd513);
        repeat (6) @(negedge clock);
        reset = 1'b1;
        #1;
        check("t6_reset_tw_out", 32'(tw_bus.TW_out), 32'd0);
        check("t6_reset_ack",    32'(tw_bus.tw_ack), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clock);
        check("t6_reset_hold_ack", 32'(tw_bus.tw_ack), 32'd0);
        tw_bus.expand = 26'd100;
        reset         = 1'b0;
        exp_q.push_back(32'd100);
        wait_result("t6_100", LAT);

        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
